// File: rtl/dino_reward_judge.sv
// dino_reward_judge
//   Grades each Bot jump decision and produces its training inputs.
//   A jump request is accepted only from IDLE while the dino is on the ground.
//   The jump is tracked until it lands, collides or times out. Its grade is then
//   shown on Qstate for exactly one cycle.
//   Reward codes: 01 good jump, 10 hit while not jumping, 11 bad jump.
//   Every output is registered, so each decision appears one cycle after the
//   input edge that caused it.
//
// Ports
//   clk            in   1   system clock
//   reset          in   1   asynchronous active-high reset
//   state          in   2   game state; judging is active only while state == GAME_RUN
//   jump_req       in   1   Bot prediction (level)
//   position       in   10  left x of the closest cactus (grows as the cactus approaches)
//   dino_on_ground in   1   dino rests on the ground
//   collision      in   1   dino and cactus overlap
//   jump_cmd       out  1   one-cycle launch pulse to the physics block
//   success_jump   out  1   one-cycle pulse, coincident with jump_cmd
//   Qstate         out  2   reward code, nonzero for one cycle per graded event
//   busy           out  1   FSM is not in IDLE
//   good_cnt       out  16  count of 01 grades (only with JUDGE_STATS_EN)
//   bad_cnt        out  16  count of 10/11 grades (only with JUDGE_STATS_EN)
//
// Build option
//   JUDGE_STATS_EN  enables the saturating grade counters. When it is not
//                   defined, good_cnt and bad_cnt are tied to zero.
//
// State table
//   IDLE     | waiting for a legal jump request or a ground collision
//   AIR      | jump launched; counting air cycles until the outcome is known
//   REPORT   | Qstate carries the grade for this single cycle
//   COOLDOWN | waiting for the collision to clear and the dino to be grounded

module dino_reward_judge #(
   parameter logic [9:0]  PASS_POS    = 10'd560,
   parameter logic [25:0] AIR_MAX_CYC = 26'd60000000,
   parameter logic [1:0]  GAME_RUN    = 2'b10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  state,
   input  logic        jump_req,
   input  logic [9:0]  position,
   input  logic        dino_on_ground,
   input  logic        collision,
   output logic        jump_cmd,
   output logic        success_jump,
   output logic [1:0]  Qstate,
   output logic        busy,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      AIR      = 2'd1,
      REPORT   = 2'd2,
      COOLDOWN = 2'd3
   } fsm_t;

   fsm_t        fsm, fsm_nxt;
   logic [25:0] air_cnt, air_cnt_nxt;
   logic        passed, passed_nxt;
   logic        jump_nxt;
   logic [1:0]  q_nxt;
   logic        at_pass;

   assign at_pass = (position >= PASS_POS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm          <= IDLE;
         air_cnt      <= '0;
         passed       <= 1'b0;
         jump_cmd     <= 1'b0;
         success_jump <= 1'b0;
         Qstate       <= 2'b00;
         busy         <= 1'b0;
      end else begin
         fsm          <= fsm_nxt;
         air_cnt      <= air_cnt_nxt;
         passed       <= passed_nxt;
         jump_cmd     <= jump_nxt;
         success_jump <= jump_nxt;
         Qstate       <= q_nxt;
         busy         <= (fsm_nxt != IDLE);
      end
   end

   always_comb begin
      fsm_nxt     = fsm;
      air_cnt_nxt = air_cnt;
      passed_nxt  = passed;
      jump_nxt    = 1'b0;
      q_nxt       = 2'b00;
      if (state != GAME_RUN) begin
         fsm_nxt = IDLE;
      end else begin
         case (fsm)
            IDLE: begin
               // A collision outranks a same-cycle jump request.
               if (collision) begin
                  fsm_nxt = REPORT;
                  q_nxt   = 2'b10;
               end else if (jump_req && dino_on_ground) begin
                  fsm_nxt     = AIR;
                  jump_nxt    = 1'b1;
                  air_cnt_nxt = '0;
                  passed_nxt  = 1'b0;
               end
            end
            AIR: begin
               // The counter stops at AIR_MAX_CYC because the timeout leaves AIR first.
               air_cnt_nxt = air_cnt + 26'd1;
               if (at_pass) passed_nxt = 1'b1;
               if (collision)
                  q_nxt = 2'b11;
               else if (air_cnt == AIR_MAX_CYC - 26'd1)
                  q_nxt = 2'b11;
               else if (dino_on_ground && air_cnt >= 26'd2)
                  // The ground flag lags jump_cmd, so the first two air cycles are not treated as a landing.
                  q_nxt = (passed || at_pass) ? 2'b01 : 2'b11;
               if (q_nxt != 2'b00) fsm_nxt = REPORT;
            end
            REPORT: fsm_nxt = COOLDOWN;
            COOLDOWN: begin
               // Hold here until the collision clears so a single hit is graded only once.
               if (!collision && dino_on_ground) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
         endcase
      end
   end

`ifdef JUDGE_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else begin
         if (q_nxt == 2'b01 && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
         if (q_nxt[1] && bad_cnt != 16'hFFFF)        bad_cnt  <= bad_cnt + 16'd1;
      end
   end
`else
   assign good_cnt = 16'd0;
   assign bad_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_dino_reward_judge.sv
module tb_dino_reward_judge;

   localparam int AIR_MAX = 100;
   localparam int PASS    = 560;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  state;
   logic        jump_req;
   logic [9:0]  position;
   logic        dino_on_ground;
   logic        collision;
   logic        jump_cmd;
   logic        success_jump;
   logic [1:0]  Qstate;
   logic        busy;
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;

   dino_reward_judge #(.AIR_MAX_CYC(26'd100)) dut (
      .clk(clk), .reset(reset), .state(state), .jump_req(jump_req),
      .position(position), .dino_on_ground(dino_on_ground), .collision(collision),
      .jump_cmd(jump_cmd), .success_jump(success_jump), .Qstate(Qstate),
      .busy(busy), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
   );

   always #5 clk = ~clk;

   int    n_cmp = 0;
   int    n_bad = 0;
   string scen  = "reset";

   // Behavioural reference: "is the dino mid-jump", "how many air cycles so far",
   // "grade to show this cycle", "waiting for the hit/landing to settle".
   bit m_airborne, m_waiting, m_passed, m_launch;
   int m_air_n, m_show, m_good, m_badn;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s/%s: got %0d expected %0d", scen, tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_airborne = 0; m_waiting = 0; m_passed = 0; m_launch = 0;
      m_air_n = 0; m_show = 0; m_good = 0; m_badn = 0;
   endtask

   task automatic model_step();
      int grade;
      m_launch = 0;
      if (state != 2'b10) begin
         m_airborne = 0; m_waiting = 0; m_show = 0;
      end else if (m_show != 0) begin
         m_show = 0; m_waiting = 1;
      end else if (m_waiting) begin
         if (!collision && dino_on_ground) m_waiting = 0;
      end else if (m_airborne) begin
         grade = 0;
         m_air_n++;
         if (int'(position) >= PASS) m_passed = 1;
         if (collision)                          grade = 3;
         else if (m_air_n == AIR_MAX)            grade = 3;
         else if (dino_on_ground && m_air_n >= 3) grade = m_passed ? 1 : 3;
         if (grade != 0) begin
            m_airborne = 0; m_show = grade;
         end
      end else begin
         if (collision) m_show = 2;
         else if (jump_req && dino_on_ground) begin
            m_airborne = 1; m_air_n = 0; m_passed = 0; m_launch = 1;
         end
      end
      if (m_show == 1 && m_good < 65535) m_good++;
      if (m_show >= 2 && m_badn < 65535) m_badn++;
   endtask

   task automatic check_outs();
      chk("jump_cmd", int'(jump_cmd), int'(m_launch));
      chk("success_jump", int'(success_jump), int'(m_launch));
      chk("Qstate", int'(Qstate), m_show);
      chk("busy", int'(busy), int'(m_airborne || m_waiting || m_show != 0));
`ifdef JUDGE_STATS_EN
      chk("good_cnt", int'(good_cnt), m_good);
      chk("bad_cnt", int'(bad_cnt), m_badn);
`else
      chk("good_cnt", int'(good_cnt), 0);
      chk("bad_cnt", int'(bad_cnt), 0);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_outs();
   endtask

   task automatic async_reset();
      #3 reset = 1'b1;
      #1;
      model_reset();
      check_outs();
      chk("rst_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      check_outs();
      reset = 1'b0;
   endtask

   task automatic settle();
      jump_req = 0; collision = 0; dino_on_ground = 1;
      repeat (3) tick();
   endtask

   task automatic launch();
      dino_on_ground = 1; jump_req = 1; collision = 0;
      tick();
      chk("launch_cmd", int'(jump_cmd), 1);
      jump_req = 0; dino_on_ground = 0;
   endtask

   task automatic do_jump(input int air_len, input int p0, input int p1, input int exp_code);
      launch();
      for (int i = 0; i < air_len; i++) begin
         position = 10'(p0 + ((p1 - p0) * i) / (air_len - 1));
         tick();
         chk("in_air_q", int'(Qstate), 0);
      end
      dino_on_ground = 1;
      tick();
      chk("landing_grade", int'(Qstate), exp_code);
      tick();
      chk("after_grade", int'(Qstate), 0);
      settle();
   endtask

   task automatic ground_hit();
      dino_on_ground = 1; collision = 1; jump_req = 1;
      tick();
      chk("hit_no_cmd", int'(jump_cmd), 0);
      chk("hit_grade", int'(Qstate), 2);
      collision = 0; jump_req = 0;
      tick();
      chk("hit_once", int'(Qstate), 0);
      settle();
   endtask

   initial begin
      reset = 1; state = 2'b10; jump_req = 0; position = 10'd400;
      dino_on_ground = 1; collision = 0;
      model_reset();
      #1;
      check_outs();
      @(posedge clk); @(posedge clk);
      #1 reset = 0;
      tick();

      scen = "good";
      do_jump(40, 500, 570, 1);

      scen = "early";
      do_jump(40, 400, 400, 3);

      scen = "midair_hit";
      position = 10'd450;
      launch();
      repeat (9) tick();
      collision = 1;
      tick();
      chk("hit_grade", int'(Qstate), 3);
      repeat (5) begin
         tick();
         chk("no_regrade", int'(Qstate), 0);
         chk("cool_busy", int'(busy), 1);
      end
      collision = 0; dino_on_ground = 1;
      tick();
      chk("back_idle", int'(busy), 0);
      settle();

      scen = "ground_hit";
      ground_hit();

      scen = "timeout";
      launch();
      repeat (AIR_MAX - 1) tick();
      chk("pre_timeout", int'(Qstate), 0);
      tick();
      chk("timeout_grade", int'(Qstate), 3);
      settle();

      scen = "async_reset";
      launch();
      repeat (5) tick();
      async_reset();
      settle();

      scen = "not_running";
      launch();
      repeat (3) tick();
      state = 2'b01;
      tick();
      chk("idle_busy", int'(busy), 0);
      state = 2'b10;
      settle();

      scen = "stats";
      repeat (3) do_jump(20, 540, 600, 1);
      repeat (2) ground_hit();
`ifdef JUDGE_STATS_EN
      chk("good_total", int'(good_cnt), 3);
      chk("bad_total", int'(bad_cnt), 2);
`else
      chk("good_total", int'(good_cnt), 0);
      chk("bad_total", int'(bad_cnt), 0);
`endif

      scen = "random";
      for (int c = 0; c < 4000; c++) begin
         state          = ($urandom_range(0, 40) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
         jump_req       = ($urandom_range(0, 3) == 0);
         collision      = ($urandom_range(0, 24) == 0);
         position       = 10'($urandom_range(380, 640));
         if ($urandom_range(0, 7) == 0) dino_on_ground = ~dino_on_ground;
         if ($urandom_range(0, 799) == 0) async_reset();
         else tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
